ttt_game_core: RTL and testbench

- Parametrised N×N, K-in-a-row game engine. Successor to the fixed 3×3 tic-tac-toe board logic.
- Accepts validated moves through a valid/ready handshake and alternates turns in hardware.
- Detects wins with a sequential line scan, and detects draws.
- Sits between the keypad decoder (upstream) and the 7-seg/dot-matrix renderers (downstream), which read `board`, `turn_o` and `result`.

---
 rtl/ttt_pkg.sv | 33 +++
 rtl/ttt_line_checker.sv | 53 +++++
 rtl/ttt_game_core.sv | 171 +++++++++++++++++
 tb/tb_ttt_game_core.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared encodings for the N x N, K-in-a-row game engine.
package ttt_pkg;

  // Cell contents as they appear in the packed board output
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  // Game result codes
  localparam logic [1:0] RES_PLAY = 2'b00;
  localparam logic [1:0] RES_XWIN = 2'b01;
  localparam logic [1:0] RES_OWIN = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // Line-scan directions from a start cell
  localparam logic [1:0] DIR_R  = 2'd0;  // right
  localparam logic [1:0] DIR_D  = 2'd1;  // down
  localparam logic [1:0] DIR_DR = 2'd2;  // down-right
  localparam logic [1:0] DIR_DL = 2'd3;  // down-left

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Result code reported when the given player completes a line
  function automatic logic [1:0] win_code(input logic [1:0] player);
    return (player == CELL_O) ? RES_OWIN : RES_XWIN;
  endfunction

endpackage

// File: rtl/ttt_line_checker.sv
// Combinational test of one candidate line: K cells from a start cell in one
// direction, all in bounds and all owned by the given player.
module ttt_line_checker
  import ttt_pkg::*;
#(
  parameter  int N    = 3,
  parameter  int K    = 3,
  localparam int IDXW = $clog2(N*N)
) (
  input  logic [2*N*N-1:0] board_i,
  input  logic [IDXW-1:0]  cell_i,
  input  logic [1:0]       dir_i,
  input  logic [1:0]       player_i,
  output logic             win_o
);

  logic [1:0] cells [N*N];

  for (genvar g = 0; g < N*N; g++) begin : g_cells
    assign cells[g] = board_i[2*g +: 2];
  end

  // Walk the K cells of the candidate; any out-of-bounds step or foreign cell kills it
  always_comb begin
    int row;
    int col;
    int dr;
    int dc;
    int r;
    int c;
    win_o = 1'b1;
    row   = int'(cell_i) / N;
    col   = int'(cell_i) % N;
    dr    = 0;
    dc    = 0;
    case (dir_i)
      DIR_R:   begin dr = 0; dc =  1; end
      DIR_D:   begin dr = 1; dc =  0; end
      DIR_DR:  begin dr = 1; dc =  1; end
      default: begin dr = 1; dc = -1; end
    endcase
    for (int unsigned k = 0; k < K; k++) begin
      r = row + int'(k) * dr;
      c = col + int'(k) * dc;
      if (r < 0 || r >= N || c < 0 || c >= N) begin
        win_o = 1'b0;
      end else if (cells[IDXW'(r*N + c)] != player_i) begin
        win_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ttt_game_core.sv
// N x N, K-in-a-row game engine: move handshake, turn alternation, sequential
// win scan (one start-cell/direction candidate per cycle) and draw detection.
// Optional single-step undo is built when TTT_UNDO_EN is defined.
module ttt_game_core
  import ttt_pkg::*;
#(
  parameter  int N    = 3,
  parameter  int K    = 3,
  localparam int IDXW = $clog2(N*N),
  localparam int CNTW = $clog2(N*N+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef TTT_UNDO_EN
  input  logic              undo,
`endif
  input  logic              move_valid,
  input  logic [IDXW-1:0]   move_idx,
  output logic              move_ready,
  output logic              move_reject,
  output logic [2*N*N-1:0]  board,
  output logic              turn_o,
  output logic [1:0]        result,
  output logic [CNTW-1:0]   move_count,
  output logic              busy
);

  localparam int              CELLS     = N*N;
  localparam logic [IDXW:0]   CELLS_EXT = (IDXW+1)'(CELLS);
  localparam logic [IDXW-1:0] LAST_CELL = IDXW'(CELLS - 1);
  localparam logic [CNTW-1:0] FULL      = CNTW'(CELLS);

  state_t          state_q;
  logic [1:0]      cells_q [CELLS];
  logic            turn_q;
  logic [1:0]      result_q;
  logic [CNTW-1:0] count_q;
  logic            reject_q;
  logic [IDXW-1:0] scan_c_q;
  logic [1:0]      scan_d_q;
`ifdef TTT_UNDO_EN
  logic [IDXW-1:0] hist_idx_q;
  logic            hist_v_q;
`endif

  logic [1:0] mover;
  logic       undo_req;
  logic       handshake;
  logic       idx_bad;
  logic       line_win;
  logic       scan_last;

`ifdef TTT_UNDO_EN
  assign undo_req = undo;
`else
  assign undo_req = 1'b0;
`endif

  assign mover      = turn_q ? CELL_O : CELL_X;
  assign move_ready = (state_q == ST_PLAY) && !undo_req;
  assign handshake  = move_valid && move_ready;
  // Range test first; the occupancy read is only meaningful for in-range indices
  assign idx_bad    = ({1'b0, move_idx} >= CELLS_EXT) || (cells_q[move_idx] != CELL_EMPTY);
  assign scan_last  = (scan_c_q == LAST_CELL) && (scan_d_q == DIR_DL);

  for (genvar g = 0; g < CELLS; g++) begin : g_board
    assign board[2*g +: 2] = cells_q[g];
  end

  assign move_reject = reject_q;
  assign turn_o      = turn_q;
  assign result      = result_q;
  assign move_count  = count_q;
  assign busy        = (state_q == ST_CHECK);

  ttt_line_checker #(
    .N (N),
    .K (K)
  ) u_line (
    .board_i  (board),
    .cell_i   (scan_c_q),
    .dir_i    (scan_d_q),
    .player_i (mover),
    .win_o    (line_win)
  );

  // Game FSM: start overrides every state; moves in PLAY, line scan in CHECK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cells_q    <= '{default: CELL_EMPTY};
      turn_q     <= 1'b0;
      result_q   <= RES_PLAY;
      count_q    <= '0;
      reject_q   <= 1'b0;
      scan_c_q   <= '0;
      scan_d_q   <= '0;
`ifdef TTT_UNDO_EN
      hist_idx_q <= '0;
      hist_v_q   <= 1'b0;
`endif
    end else begin
      reject_q <= 1'b0;
      if (start) begin
        state_q  <= ST_PLAY;
        cells_q  <= '{default: CELL_EMPTY};
        turn_q   <= 1'b0;
        result_q <= RES_PLAY;
        count_q  <= '0;
        scan_c_q <= '0;
        scan_d_q <= '0;
`ifdef TTT_UNDO_EN
        hist_v_q <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_PLAY: begin
`ifdef TTT_UNDO_EN
            if (undo) begin
              if (hist_v_q) begin
                cells_q[hist_idx_q] <= CELL_EMPTY;
                count_q             <= count_q - CNTW'(1);
                turn_q              <= ~turn_q;
                hist_v_q            <= 1'b0;
              end
            end else
`endif
            if (handshake) begin
              if (idx_bad) begin
                reject_q <= 1'b1;
              end else begin
                cells_q[move_idx] <= mover;
                count_q           <= count_q + CNTW'(1);
                scan_c_q          <= '0;
                scan_d_q          <= '0;
                state_q           <= ST_CHECK;
`ifdef TTT_UNDO_EN
                hist_idx_q        <= move_idx;
                hist_v_q          <= 1'b1;
`endif
              end
            end
          end
          ST_CHECK: begin
            if (line_win) begin
              result_q <= win_code(mover);
              state_q  <= ST_DONE;
            end else if (scan_last) begin
              if (count_q == FULL) begin
                result_q <= RES_DRAW;
                state_q  <= ST_DONE;
              end else begin
                turn_q  <= ~turn_q;
                state_q <= ST_PLAY;
              end
            end else begin
              scan_d_q <= scan_d_q + 2'd1;
              if (scan_d_q == DIR_DL) begin
                scan_c_q <= scan_c_q + IDXW'(1);
              end
            end
          end
          ST_DONE: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttt_game_core.sv
`timescale 1ns/1ps
module tb_ttt_game_core;

  localparam int N     = 3;
  localparam int K     = 3;
  localparam int CELLS = N*N;
`ifdef TTT_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  localparam int MD_IDLE  = 0;
  localparam int MD_PLAY  = 1;
  localparam int MD_CHECK = 2;
  localparam int MD_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s, valid_s, undo_s;
  logic [3:0]  idx_s;
  logic        ready, reject, turn, busy;
  logic [17:0] board;
  logic [1:0]  result;
  logic [3:0]  count;

  logic        start4, valid4;
  logic [3:0]  idx4;
  logic        ready4, reject4, turn4, busy4;
  logic [31:0] board4;
  logic [1:0]  result4;
  logic [4:0]  count4;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  ttt_game_core #(.N(3), .K(3)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start_s),
`ifdef TTT_UNDO_EN
    .undo       (undo_s),
`endif
    .move_valid (valid_s),
    .move_idx   (idx_s),
    .move_ready (ready),
    .move_reject(reject),
    .board      (board),
    .turn_o     (turn),
    .result     (result),
    .move_count (count),
    .busy       (busy)
  );

  ttt_game_core #(.N(4), .K(3)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start4),
`ifdef TTT_UNDO_EN
    .undo       (1'b0),
`endif
    .move_valid (valid4),
    .move_idx   (idx4),
    .move_ready (ready4),
    .move_reject(reject4),
    .board      (board4),
    .turn_o     (turn4),
    .result     (result4),
    .move_count (count4),
    .busy       (busy4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the N=3 instance ----------------
  int m_board [CELLS];
  int m_turn, m_result, m_count, m_mode, m_left, m_outcome, m_hidx;
  bit m_reject, m_hv;

  // True when player p owns K consecutive in-bounds cells from c in direction d
  function automatic bit line_owned(int c, int d, int p);
    int r0, c0, dr, dc, rr, cc;
    r0 = c / N;
    c0 = c % N;
    case (d)
      0: begin dr = 0; dc =  1; end
      1: begin dr = 1; dc =  0; end
      2: begin dr = 1; dc =  1; end
      default: begin dr = 1; dc = -1; end
    endcase
    for (int k = 0; k < K; k++) begin
      rr = r0 + k*dr;
      cc = c0 + k*dc;
      if (rr < 0 || rr >= N || cc < 0 || cc >= N) return 1'b0;
      if (m_board[rr*N + cc] != p) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Position in scan order (cell-major, 4 directions each) of the first win, or -1
  function automatic int first_win(int p);
    for (int c = 0; c < CELLS; c++)
      for (int d = 0; d < 4; d++)
        if (line_owned(c, d, p)) return c*4 + d;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) m_board[i] = 0;
    m_turn = 0; m_result = 0; m_count = 0; m_hv = 1'b0;
  endtask

  task automatic model_step();
    int p, w;
    m_reject = 1'b0;
    if (start_s) begin
      model_clear();
      m_mode = MD_PLAY;
      return;
    end
    case (m_mode)
      MD_PLAY: begin
        if (UNDO_EN && undo_s) begin
          if (m_hv) begin
            m_board[m_hidx] = 0;
            m_count--;
            m_turn = 1 - m_turn;
            m_hv = 1'b0;
          end
        end else if (valid_s) begin
          if (int'(idx_s) >= CELLS) m_reject = 1'b1;
          else if (m_board[int'(idx_s)] != 0) m_reject = 1'b1;
          else begin
            p = m_turn + 1;
            m_board[int'(idx_s)] = p;
            m_count++;
            m_hv = 1'b1;
            m_hidx = int'(idx_s);
            w = first_win(p);
            if (w >= 0) begin
              m_left = w + 1;
              m_outcome = p;
            end else begin
              m_left = 4*CELLS;
              m_outcome = (m_count == CELLS) ? 3 : 0;
            end
            m_mode = MD_CHECK;
          end
        end
      end
      MD_CHECK: begin
        m_left--;
        if (m_left == 0) begin
          if (m_outcome == 0) begin
            m_turn = 1 - m_turn;
            m_mode = MD_PLAY;
          end else begin
            m_result = m_outcome;
            m_mode = MD_DONE;
          end
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_clear();
      m_mode = MD_IDLE;
      m_reject = 1'b0;
    end else begin
      model_step();
    end
  end

  function automatic logic [17:0] exp_board();
    logic [17:0] b;
    b = '0;
    for (int i = CELLS-1; i >= 0; i--) b = {b[15:0], 2'(m_board[i])};
    return b;
  endfunction

  // Every-cycle comparison of the N=3 instance against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("board",  board,  exp_board());
      chk("turn",   turn,   m_turn);
      chk("result", result, m_result);
      chk("count",  count,  m_count);
      chk("reject", reject, m_reject);
      chk("busy",   busy,   m_mode == MD_CHECK);
      chk("ready",  ready,  (m_mode == MD_PLAY) && !(UNDO_EN && undo_s));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit s, input bit v, input int idx, input bit u);
    start_s = s; valid_s = v; idx_s = 4'(idx); undo_s = u;
    @(posedge clk); #2;
    start_s = 1'b0; valid_s = 1'b0; undo_s = 1'b0;
  endtask

  task automatic play(input int idx, output int lat);
    cyc(1'b0, 1'b1, idx, 1'b0);
    lat = 0;
    while (busy === 1'b1 && lat < 400) begin
      @(posedge clk); #2;
      lat++;
    end
    if (lat >= 400) begin
      n_checks++; n_fail++;
      $display("FAIL busy_timeout: busy still high after %0d cycles, required low", lat);
    end
  endtask

  task automatic cyc4(input bit s, input bit v, input int idx);
    start4 = s; valid4 = v; idx4 = 4'(idx);
    @(posedge clk); #2;
    start4 = 1'b0; valid4 = 1'b0;
  endtask

  task automatic play4(input int idx, output int lat);
    cyc4(1'b0, 1'b1, idx);
    lat = 0;
    while (busy4 === 1'b1 && lat < 400) begin
      @(posedge clk); #2;
      lat++;
    end
    if (lat >= 400) begin
      n_checks++; n_fail++;
      $display("FAIL busy4_timeout: busy still high after %0d cycles, required low", lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seq_win [5]  = '{0, 3, 1, 4, 2};
    int seq_draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int seq_ad [5]   = '{3, 0, 6, 1, 9};
    int seq_wrap [5] = '{2, 8, 3, 9, 4};
    bit s;

    rst = 1'b1;
    start_s = 1'b0; valid_s = 1'b0; undo_s = 1'b0; idx_s = '0;
    start4 = 1'b0; valid4 = 1'b0; idx4 = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Reset values
    chk("rst_board", board, 18'h0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_result", result, 2'b00);
    chk("rst_turn", turn, 1'b0);
    cmp_en = 1'b1;

    // X wins on the top row
    cyc(1'b1, 1'b0, 0, 1'b0);
    chk("start_ready", ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      play(seq_win[i], lat);
      chk("win_lat", lat, (i == 4) ? 1 : 36);
    end
    chk("win_result", result, 2'b01);
    chk("win_board",  board,  18'h00295);
    chk("win_board_lo", board[5:0], 6'b010101);
    chk("win_ready",  ready,  1'b0);
    chk("model_win_result", m_result, 1);
    repeat (3) cyc(1'b0, 1'b1, 5, 1'b0);
    chk("done_hold_count", count, 4'd5);

    // Rejects: occupied cell and out-of-range index
    cyc(1'b1, 1'b0, 0, 1'b0);
    play(4, lat);
    cyc(1'b0, 1'b1, 4, 1'b0);
    chk("rej_pulse", reject, 1'b1);
    chk("rej_board", board, 18'h00100);
    chk("rej_turn",  turn,  1'b1);
    chk("rej_count", count, 4'd1);
    cyc(1'b0, 1'b1, 9, 1'b0);
    chk("rej9_pulse", reject, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b0);
    chk("rej_clear", reject, 1'b0);

    // Draw: nine moves, each scan 36 cycles
    cyc(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      play(seq_draw[i], lat);
      chk("draw_lat", lat, 36);
    end
    chk("draw_result", result, 2'b11);
    chk("draw_count",  count,  4'd9);
    chk("draw_board",  board,  18'h16A59);
    chk("model_draw_result", m_result, 3);

    // start during CHECK
    cyc(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b1, 4, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);
    chk("midchk_busy", busy, 1'b1);
    cyc(1'b1, 1'b0, 0, 1'b0);
    chk("midchk_board", board, 18'h0);
    chk("midchk_turn",  turn,  1'b0);
    chk("midchk_ready", ready, 1'b1);
    chk("midchk_busy0", busy,  1'b0);

    // Asynchronous reset mid-game
    play(0, lat);
    cyc(1'b0, 1'b1, 1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_board", board, 18'h0);
    chk("arst_count", count, 4'd0);
    chk("arst_busy",  busy,  1'b0);
    chk("arst_ready", ready, 1'b0);
    chk("arst_turn",  turn,  1'b0);
    @(posedge clk); #2 rst = 1'b0;

`ifdef TTT_UNDO_EN
    cyc(1'b1, 1'b0, 0, 1'b0);
    play(0, lat);
    cyc(1'b0, 1'b0, 0, 1'b1);
    chk("undo_board", board, 18'h0);
    chk("undo_turn",  turn,  1'b0);
    chk("undo_count", count, 4'd0);
    cyc(1'b0, 1'b0, 0, 1'b1);
    chk("undo2_count", count, 4'd0);
    chk("undo2_turn",  turn,  1'b0);
    cyc(1'b0, 1'b1, 4, 1'b1);
    chk("undo_mv_count", count, 4'd0);
    chk("undo_mv_busy",  busy,  1'b0);
`endif

    // Randomized play against the model
    for (int i = 0; i < 15000; i++) begin
      if (m_mode == MD_DONE || m_mode == MD_IDLE) s = ($urandom_range(0, 99) < 20);
      else s = ($urandom_range(0, 999) < 3);
      cyc(s, 1'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
          UNDO_EN && ($urandom_range(0, 9) == 0));
    end

    // N=4, K=3 instance: anti-diagonal win, then no wrap across rows
    cyc4(1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      play4(seq_ad[i], lat);
      if (i == 0) chk("n4_lat", lat, 64);
    end
    chk("n4_ad_result", result4, 2'b01);
    chk("n4_ad_ready",  ready4,  1'b0);
    cyc4(1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) play4(seq_wrap[i], lat);
    chk("n4_wrap_result", result4, 2'b00);
    chk("n4_wrap_turn",   turn4,   1'b1);
    chk("n4_wrap_count",  count4,  5'd5);
    chk("n4_wrap_ready",  ready4,  1'b1);
    chk("n4_wrap_cell4",  board4[9:8], 2'b01);

    cmp_en = 1'b0;
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
